// File: rtl/mdpsk_mod.sv
// mdpsk_mod -- M-ary differential PSK modulator.
//
// Serial bits arrive over a valid/ready handshake. Every SYM_CYCLES clocks the
// collected BITS_PER_SYM bits become one symbol. That symbol advances the
// differential phase state, which offsets an NCO phase that feeds a sine table.
//
// Optional build macro: MDPSK_GRAY_EN. When it is defined, symbols are
// Gray-decoded before they are added to the phase state. Otherwise natural
// binary is used.
//
// Ports:
//   clk        : system clock, all logic on the rising edge
//   reset_n    : synchronous active-low reset
//   freq_word  : NCO increment per clock
//   bit_in     : serial data bit
//   bit_valid  : bit_in is valid
//   bit_ready  : a bit can be accepted this cycle (registered)
//   sym_strobe : one-cycle pulse after each symbol boundary
//   diff_state : current differential phase state, 0..2^BITS_PER_SYM-1
//   underrun   : one-cycle pulse when a boundary finds an incomplete symbol
//   wave_out   : signed carrier sample
//   wave_valid : wave_out pipeline has filled since reset
module mdpsk_mod #(
    parameter int DATA_W       = 8,
    parameter int PHASE_W      = 16,
    parameter int LUT_AW       = 8,
    parameter int BITS_PER_SYM = 1,
    parameter int SYM_CYCLES   = 50
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [PHASE_W-1:0]        freq_word,
    input  logic                      bit_in,
    input  logic                      bit_valid,
    output logic                      bit_ready,
    output logic                      sym_strobe,
    output logic [BITS_PER_SYM-1:0]   diff_state,
    output logic                      underrun,
    output logic signed [DATA_W-1:0]  wave_out,
    output logic                      wave_valid
);
    localparam int CNT_W  = $clog2(SYM_CYCLES);
    localparam int BC_W   = $clog2(BITS_PER_SYM + 1);
    localparam int LUT_N  = 1 << LUT_AW;
    localparam int STAGES = 1;

    // Sine table entry. A Taylor series over [-pi, pi] keeps this to plain
    // real arithmetic so it folds at elaboration.
    function automatic logic signed [DATA_W-1:0] lut_val(input int k);
        real pi, amp, x, term, sum;
        int  r;
        pi  = 3.14159265358979323846;
        amp = real'((1 << (DATA_W - 1)) - 1);
        x   = 2.0 * pi * real'(k) / real'(LUT_N);
        if (x > pi) x = x - 2.0 * pi;
        term = x;
        sum  = x;
        for (int i = 1; i < 10; i++) begin
            term = -term * x * x / real'((2 * i) * (2 * i + 1));
            sum  = sum + term;
        end
        sum = amp * sum;
        if (sum >= 0.0) r = $rtoi(sum + 0.5);
        else            r = -$rtoi(0.5 - sum);
        return DATA_W'(r);
    endfunction

    logic signed [DATA_W-1:0] lut [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        assign lut[k] = lut_val(k);
    end

    logic [PHASE_W-1:0]      acc;
    logic [CNT_W-1:0]        sym_cnt;
    logic [BC_W-1:0]         bit_cnt, bit_cnt_nxt;
    logic [BITS_PER_SYM-1:0] shreg, shreg_nxt, map_s;
    logic [BITS_PER_SYM:0]   sh_ext;
    logic [LUT_AW-1:0]       idx;
    logic [STAGES:0]         vld_pipe;
    logic [PHASE_W-1:0]      phase;
    logic                    boundary, full, accept;

    assign boundary = (sym_cnt == CNT_W'(SYM_CYCLES - 1));
    assign full     = (bit_cnt == BC_W'(BITS_PER_SYM));
    assign accept   = bit_valid & bit_ready;
    assign sh_ext   = {shreg, bit_in};  // first bit received ends up as the MSB
    assign phase    = acc + (PHASE_W'(diff_state) << (PHASE_W - BITS_PER_SYM));
    assign wave_valid = vld_pipe[STAGES];

    // Symbol to phase-step mapping.
    always_comb begin
        map_s = shreg;
`ifdef MDPSK_GRAY_EN
        for (int i = BITS_PER_SYM - 2; i >= 0; i--)
            map_s[i] = map_s[i+1] ^ shreg[i];
`endif
    end

    // A full buffer is consumed on the boundary. Otherwise partial bits are
    // kept, and a bit accepted on the boundary edge counts toward the next symbol.
    always_comb begin
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        if (boundary && full) begin
            bit_cnt_nxt = '0;
            shreg_nxt   = '0;
        end else if (accept) begin
            bit_cnt_nxt = bit_cnt + BC_W'(1);
            shreg_nxt   = sh_ext[BITS_PER_SYM-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc        <= '0;
            sym_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            diff_state <= '0;
            bit_ready  <= 1'b0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
            idx        <= '0;
            wave_out   <= '0;
            vld_pipe   <= '0;
        end else begin
            acc        <= acc + freq_word;
            sym_cnt    <= boundary ? '0 : sym_cnt + CNT_W'(1);
            sym_strobe <= boundary;
            underrun   <= boundary && !full;
            if (boundary && full)
                diff_state <= diff_state + map_s;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            bit_ready  <= (bit_cnt_nxt < BC_W'(BITS_PER_SYM));
            // Two-stage output: phase index, then table read.
            idx        <= phase[PHASE_W-1 -: LUT_AW];
            wave_out   <= lut[idx];
            vld_pipe   <= {vld_pipe[STAGES-1:0], 1'b1};
        end
    end
endmodule

// File: tb/tb_mdpsk_mod.sv
// Directed bench for mdpsk_mod. u1 uses the default DBPSK configuration.
// u2 is a DQPSK instance with a short 10-clock symbol period.
module tb_mdpsk_mod;
`ifdef MDPSK_GRAY_EN
    localparam bit GRAY = 1'b1;
`else
    localparam bit GRAY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1_n, rst2_n;
    logic [15:0] fw1, fw2;
    logic        bi1, bv1, br1, ss1, un1, wv1;
    logic        bi2, bv2, br2, ss2, un2, wv2;
    logic [0:0]  ds1;
    logic [1:0]  ds2;
    logic signed [7:0] wo1, wo2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    mdpsk_mod u1 (
        .clk(clk), .reset_n(rst1_n), .freq_word(fw1), .bit_in(bi1),
        .bit_valid(bv1), .bit_ready(br1), .sym_strobe(ss1), .diff_state(ds1),
        .underrun(un1), .wave_out(wo1), .wave_valid(wv1)
    );

    mdpsk_mod #(.BITS_PER_SYM(2), .SYM_CYCLES(10)) u2 (
        .clk(clk), .reset_n(rst2_n), .freq_word(fw2), .bit_in(bi2),
        .bit_valid(bv2), .bit_ready(br2), .sym_strobe(ss2), .diff_state(ds2),
        .underrun(un2), .wave_out(wo2), .wave_valid(wv2)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic send1(input logic b);
        chk("u1_ready_before_send", br1, 1);
        bv1 = 1'b1; bi1 = b;
        tick();
        bv1 = 1'b0;
    endtask

    task automatic send2(input logic b);
        chk("u2_ready_before_send", br2, 1);
        bv2 = 1'b1; bi2 = b;
        tick();
        bv2 = 1'b0;
    endtask

    task automatic reset_u2();
        rst2_n = 1'b0;
        tick(); tick();
        rst2_n = 1'b1;
        cyc = 0;
    endtask

    int   acc_cnt, rdy_cnt;
    logic mdiff, pend, have, usaw;

    initial begin
        rst1_n = 1'b0; rst2_n = 1'b0;
        fw1 = 16'h4000; fw2 = 16'h0000;
        bi1 = 1'b0; bv1 = 1'b0; bi2 = 1'b0; bv2 = 1'b0;
        tick(); tick(); tick();
        chk("rst_wave", wo1, 0);
        chk("rst_wave_valid", wv1, 0);
        chk("rst_strobe", ss1, 0);
        chk("rst_underrun", un1, 0);
        chk("rst_diff", ds1, 0);
        chk("rst_ready", br1, 0);

        // ---- DBPSK, bits 1,0,1 ----
        rst1_n = 1'b1; cyc = 0;
        chk("c0_wave_valid", wv1, 0);
        tick();
        chk("c1_ready", br1, 1);
        chk("c1_wave_valid", wv1, 0);
        send1(1'b1);
        chk("ready_low_after_fill", br1, 0);
        chk("c2_wave_valid", wv1, 1);
        chk("c2_wave", wo1, 0);
        tick();
        chk("c3_wave", wo1, 127);
        run_to(49);
        chk("no_strobe_before_boundary", ss1, 0);
        tick();
        chk("sym1_strobe", ss1, 1);
        chk("sym1_diff", ds1, 1);
        chk("sym1_underrun", un1, 0);
        chk("sym1_ready_back", br1, 1);
        send1(1'b0);
        run_to(54); chk("d1_wave_q0", wo1, 0);
        tick();     chk("d1_wave_q1", wo1, -127);
        tick();     chk("d1_wave_q2", wo1, 0);
        tick();     chk("d1_wave_q3", wo1, 127);
        run_to(100);
        chk("sym2_strobe", ss1, 1);
        chk("sym2_diff", ds1, 1);
        send1(1'b1);
        run_to(150);
        chk("sym3_diff", ds1, 0);
        run_to(154); chk("d0_wave_q0", wo1, 0);
        tick();      chk("d0_wave_q1", wo1, 127);
        tick();      chk("d0_wave_q2", wo1, 0);
        tick();      chk("d0_wave_q3", wo1, -127);

        // ---- underrun: no bits across the boundary at 199 ----
        run_to(200);
        chk("ur_pulse", un1, 1);
        chk("ur_strobe", ss1, 1);
        chk("ur_diff_held", ds1, 0);
        tick();
        chk("ur_one_cycle", un1, 0);
        chk("ur_strobe_one_cycle", ss1, 0);
        send1(1'b1);
        run_to(250);
        chk("ur_next_bit_applied", ds1, 1);
        chk("ur_next_no_underrun", un1, 0);

        // ---- reset mid-run at sym_cnt=20 ----
        run_to(270);
        rst1_n = 1'b0;
        tick();
        chk("mid_rst_wave", wo1, 0);
        chk("mid_rst_wave_valid", wv1, 0);
        chk("mid_rst_strobe", ss1, 0);
        chk("mid_rst_underrun", un1, 0);
        chk("mid_rst_diff", ds1, 0);
        chk("mid_rst_ready", br1, 0);
        tick(); tick();
        rst1_n = 1'b1; cyc = 0;
        chk("rel_c0_wave_valid", wv1, 0);
        tick(); chk("rel_c1_wave_valid", wv1, 0);
        tick(); chk("rel_c2_wave_valid", wv1, 1);
                chk("rel_c2_wave", wo1, 0);
        tick(); chk("rel_c3_wave", wo1, 127);
        tick(); chk("rel_c4_wave", wo1, 0);
        tick(); chk("rel_c5_wave", wo1, -127);

        // ---- backpressure: bit_valid held high with random data ----
        acc_cnt = 0; rdy_cnt = 0; mdiff = 1'b0; pend = 1'b0; have = 1'b0; usaw = 1'b0;
        bv1 = 1'b1; bi1 = 1'($urandom);
        while (cyc <= 150) begin
            if (ss1) begin
                if (have) begin mdiff = mdiff ^ pend; have = 1'b0; end
                chk("bp_diff", ds1, mdiff);
                chk("bp_accepts_per_window", acc_cnt, 1);
                if (cyc > 50) chk("bp_ready_cycles_per_window", rdy_cnt, 1);
                acc_cnt = 0; rdy_cnt = 0;
            end
            if (un1) usaw = 1'b1;
            if (br1) rdy_cnt++;
            if (bv1 && br1) begin pend = bi1; have = 1'b1; acc_cnt++; end
            tick();
            bi1 = 1'($urandom);
        end
        bv1 = 1'b0;
        chk("bp_no_underrun", usaw, 0);
        rst1_n = 1'b0;

        // ---- DQPSK, freq_word=0: symbols 01,01,10 ----
        reset_u2();
        tick();
        send2(1'b0); send2(1'b1);
        chk("q_ready_low_full", br2, 0);
        run_to(10);
        chk("q_sym1_strobe", ss2, 1);
        chk("q_sym1_diff", ds2, 1);
        chk("q_sym1_underrun", un2, 0);
        send2(1'b0); send2(1'b1);
        chk("q_wave_d1", wo2, 127);
        run_to(20);
        chk("q_sym2_diff", ds2, 2);
        send2(1'b1); send2(1'b0);
        chk("q_wave_d2", wo2, 0);
        run_to(30);
        chk("q_sym3_diff", ds2, GRAY ? 1 : 0);
        run_to(32);
        chk("q_wave_sym3", wo2, GRAY ? 127 : 0);

        // ---- DQPSK partial symbol, then symbols 11 and 10 ----
        reset_u2();
        tick();
        send2(1'b1);
        chk("q_ready_partial", br2, 1);
        run_to(10);
        chk("q_ur_pulse", un2, 1);
        chk("q_ur_strobe", ss2, 1);
        chk("q_ur_diff_held", ds2, 0);
        tick();
        chk("q_ur_one_cycle", un2, 0);
        send2(1'b1);
        chk("q_ready_low_full2", br2, 0);
        run_to(20);
        chk("q_sym11_diff", ds2, GRAY ? 2 : 3);
        chk("q_sym11_underrun", un2, 0);
        send2(1'b1); send2(1'b0);
        chk("q_wave_sym11", wo2, GRAY ? 0 : -127);
        run_to(30);
        chk("q_sym10_diff", ds2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mdpsk_mod.md
Name: mdpsk_mod

Overview:
- Parametrised M-ary differential PSK modulator. It generalises the team's fixed 8-bit DBPSK chain (separate sine/cosine tables, clock divider and dpsk_code) into one block.
- Serial bits enter over a valid/ready handshake. Every SYM_CYCLES clocks, BITS_PER_SYM bits are grouped into a symbol and differentially encoded as a carrier phase step. The carrier comes from an internal NCO plus sine table.
- Sits between the PN/serial data source and the DAC sample path.

Parameters:
- DATA_W, 8: output sample width, signed two's complement.
- PHASE_W, 16: NCO phase accumulator width.
- LUT_AW, 8: sine table address width; 2^LUT_AW entries, LUT_AW <= PHASE_W.
- BITS_PER_SYM, 1: bits per symbol; 1 = DBPSK, 2 = DQPSK, 3 = D8PSK. Legal range 1..3.
- SYM_CYCLES, 50: clocks per symbol period, >= BITS_PER_SYM+1.

Ports:
- clk, input, 1: system clock, all logic rising-edge.
- reset_n, input, 1: synchronous, active-low reset, sampled on rising clk.
- freq_word, input, PHASE_W: NCO increment per clock; may change any cycle.
- bit_in, input, 1: serial data bit.
- bit_valid, input, 1: bit_in valid.
- bit_ready, output, 1: block can accept a bit this cycle.
- sym_strobe, output, 1: one-cycle pulse on each symbol boundary.
- diff_state, output, BITS_PER_SYM: current differential phase state (0..M-1).
- underrun, output, 1: one-cycle pulse when a boundary finds an incomplete symbol.
- wave_out, output, DATA_W: modulated carrier sample, signed.
- wave_valid, output, 1: wave_out pipeline filled.

Behaviour:
- Reset: reset_n=0 at a rising edge clears all state, mid-operation included. Cleared items: acc, sym_cnt, bit_cnt, shift register, diff_state, pipeline. Outputs after that edge: wave_out=0, wave_valid=0, sym_strobe=0, underrun=0, diff_state=0, bit_ready=0.
- bit_ready: registered; 1 when bit_cnt < BITS_PER_SYM and not in reset; deasserts the cycle after the buffer fills.
- Bit accept: bit_valid & bit_ready at the edge accepts a bit. It is shifted into the shift register, first bit received = symbol MSB, and bit_cnt increments.
- sym_cnt: counts 0..SYM_CYCLES-1 and wraps. Boundary = the edge where sym_cnt == SYM_CYCLES-1.
- Boundary decision uses the pre-edge (registered) bit_cnt:
  - bit_cnt == BITS_PER_SYM: symbol s = shift register. diff_state <= (diff_state + map(s)) mod 2^BITS_PER_SYM. bit_cnt <= 0 and shift register cleared.
  - bit_cnt < BITS_PER_SYM: diff_state unchanged (phase step 0). underrun pulses next cycle. Partial bits are kept.
  - A bit accepted on the boundary edge belongs to the next symbol.
- sym_strobe is high for the one cycle after each boundary edge.
- NCO: acc <= acc + freq_word every cycle, modulo 2^PHASE_W.
- Phase: phase = acc + (diff_state << (PHASE_W-BITS_PER_SYM)), modulo 2^PHASE_W. Table index = phase[PHASE_W-1 -: LUT_AW].
- Table: LUT[k] = round(A*sin(2*pi*k/2^LUT_AW)), A = 2^(DATA_W-1)-1, generated at elaboration.
- Latency: wave_out at edge n+2 = LUT entry for acc and diff_state held during cycle n. wave_valid rises 2 cycles after the first cycle with reset_n=1, then stays 1.
- Without the option, map(s) = s (natural binary).

Optional Feature:
- Macro MDPSK_GRAY_EN.
- Defined: map(s) = Gray-decode(s). For BITS_PER_SYM=2: 00->0, 01->1, 11->2, 10->3. For BITS_PER_SYM=3: 000,001,011,010,110,111,101,100 -> 0..7.
- Undefined: map(s) = s.
- BITS_PER_SYM=1 identical either way.

Test Plan:
- Reset mid-run: freq_word=16'h4000, toggle reset_n low for 3 clks at sym_cnt=20 -> next edge all outputs 0; wave_valid back high 2 clks after release; sequence restarts 0,127,0,-127.
- DBPSK defaults, freq_word=16'h4000, feed bits 1,0,1:
  - diff_state goes 1,1,0 at successive boundaries.
  - wave_out reads 0,-127,0,127 while diff_state=1.
  - wave_out reads 0,127,0,-127 while diff_state=0.
- DQPSK (BITS_PER_SYM=2), freq_word=0: symbols 01,01,10 -> diff_state 1,2,0; wave_out 127, 0, 0.
- Underrun: DBPSK, no bit_valid across one boundary -> underrun=1 for exactly 1 cycle with sym_strobe; diff_state unchanged; next supplied bit applies at the following boundary.
- Backpressure: bit_valid held 1 with random bit_in -> exactly BITS_PER_SYM accepts per SYM_CYCLES window; bit_ready low from fill until the cycle after the boundary; underrun never asserts.
- MDPSK_GRAY_EN defined, DQPSK, freq_word=0: symbols 11 then 10 -> diff_state 2 then 1 (2+3 mod 4); undefined -> 3 then 1.
